// File: rtl/axis_frame_source.sv
// AXI-Stream frame generator: turns one length/seed command into a frame of
// incrementing byte data with tid/tdest/tuser sideband and a completed-frame count.
module axis_frame_source #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_seed,
  input  logic                  cmd_bad,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic                  m_axis_tuser,
  output logic                  status_busy,
  output logic                  status_zero_len,
  output logic [31:0]           frame_count
);

  localparam logic [LEN_WIDTH-1:0] STEP = LEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_zero_len;
  logic [31:0]           r_frame_count;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_offset;
  logic [7:0]            r_seed;
  logic                  r_bad;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;
  logic [ID_WIDTH-1:0]   r_tid;
  logic [DEST_WIDTH-1:0] r_tdest;

  logic                  w_load_first;
  logic                  w_load_next;
  logic                  w_frame_done;
  logic                  w_zero_fire;
  logic [LEN_WIDTH-1:0]  w_next_off;
  logic [LEN_WIDTH-1:0]  w_b_len;
  logic [LEN_WIDTH-1:0]  w_b_off;
  logic [LEN_WIDTH-1:0]  w_b_rem;
  logic [7:0]            w_b_seed;
  logic                  w_b_last;
  logic [DATA_WIDTH-1:0] w_b_data;
  logic [KEEP_WIDTH-1:0] w_b_keep;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_frame_done = 1'b0;
    w_zero_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          if (cmd_len == '0) begin
            w_zero_fire = 1'b1;
          end else begin
            w_state_nxt  = SEND;
            w_load_first = 1'b1;
          end
        end
      end
      SEND: begin
        if (r_tvalid && m_axis_tready) begin
          if (r_tlast) begin
            w_state_nxt  = IDLE;
            w_frame_done = 1'b1;
          end else begin
            w_load_next = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Build the upcoming beat: first beat from the live command, later beats from latched fields.
  // The offset only advances on non-last beats, so it never exceeds cmd_len and cannot wrap.
  always_comb begin
    w_next_off = r_offset + STEP;
    if (r_state == IDLE) begin
      w_b_len  = cmd_len;
      w_b_seed = cmd_seed;
      w_b_off  = '0;
    end else begin
      w_b_len  = r_len;
      w_b_seed = r_seed;
      w_b_off  = w_next_off;
    end
    w_b_rem  = w_b_len - w_b_off;
    w_b_last = (w_b_rem <= STEP);
    w_b_keep = '0;
    w_b_data = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      w_b_keep[k] = !w_b_last || (LEN_WIDTH'(k) < w_b_rem);
      w_b_data[k*8 +: 8] = w_b_keep[k] ? 8'(w_b_seed + 8'(w_b_off) + 8'(k)) : 8'h00;
    end
  end

  // Command latch, beat output registers, status and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_zero_len    <= 1'b0;
      r_frame_count <= '0;
      r_len         <= '0;
      r_offset      <= '0;
      r_seed        <= '0;
      r_bad         <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_tid         <= '0;
      r_tdest       <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt == SEND);
      r_zero_len  <= w_zero_fire;
      if (w_load_first) begin
        r_len    <= cmd_len;
        r_seed   <= cmd_seed;
        r_bad    <= cmd_bad;
        r_offset <= '0;
        r_tid    <= cmd_id;
        r_tdest  <= cmd_dest;
      end else if (w_load_next) begin
        r_offset <= w_next_off;
      end
      if (w_load_first || w_load_next) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_b_data;
        r_tkeep  <= w_b_keep;
        r_tlast  <= w_b_last;
        r_tuser  <= w_b_last && (w_load_first ? cmd_bad : r_bad);
      end else if (w_frame_done) begin
        r_tvalid      <= 1'b0;
        r_tdata       <= '0;
        r_tkeep       <= '0;
        r_tlast       <= 1'b0;
        r_tuser       <= 1'b0;
        r_tid         <= '0;
        r_tdest       <= '0;
        r_frame_count <= r_frame_count + 32'd1;
      end
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign status_busy     = r_busy;
  assign status_zero_len = r_zero_len;
  assign frame_count     = r_frame_count;
  assign m_axis_tdata    = r_tdata;
  assign m_axis_tkeep    = r_tkeep;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign m_axis_tuser    = r_tuser;
  assign m_axis_tid      = r_tid;
  assign m_axis_tdest    = r_tdest;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source (64-bit data, 16-bit length).
module tb_axis_frame_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_seed;
  logic        cmd_bad;
  logic [7:0]  cmd_id;
  logic [7:0]  cmd_dest;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic        m_axis_tuser;
  logic        status_busy;
  logic        status_zero_len;
  logic [31:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  axis_frame_source dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_seed(cmd_seed), .cmd_bad(cmd_bad), .cmd_id(cmd_id), .cmd_dest(cmd_dest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser), .status_busy(status_busy),
    .status_zero_len(status_zero_len), .frame_count(frame_count)
  );

  typedef struct {
    logic [15:0] len;
    logic [7:0]  seed;
    logic        bad;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic        stall;
    int          exp_beats;
    logic [7:0]  exp_last_keep;
    logic [63:0] exp_first_data;
    logic [63:0] exp_last_data;
    logic        exp_last_user;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Byte-offset reference: lane i of beat b is byte b*8+i, present only if below len.
  function automatic void model(input int len, input int seed, input int b,
                                output logic [63:0] d, output logic [7:0] k);
    int off;
    d = '0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      off = b * 8 + i;
      if (off < len) begin
        k[i] = 1'b1;
        d[i*8 +: 8] = 8'((seed + off) % 256);
      end
    end
  endfunction

  task automatic run_frame(input vec_t v);
    int budget;
    int beats;
    bit done;
    bit prev_stall;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_user;
    logic [7:0]  s_id;
    logic [7:0]  s_dest;
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    bit          is_last;

    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = v.len;
    cmd_seed  = v.seed;
    cmd_bad   = v.bad;
    cmd_id    = v.id;
    cmd_dest  = v.dest;
    @(negedge clk);
    // Garbage on the command bus while sending must be ignored.
    cmd_valid = 1'b0;
    cmd_len   = 16'h0003;
    cmd_seed  = 8'h5A;
    cmd_bad   = ~v.bad;
    cmd_id    = ~v.id;
    cmd_dest  = ~v.dest;
    chk("first_beat_latency", 64'(m_axis_tvalid), 64'd1);
    chk("busy_in_send", 64'(status_busy), 64'd1);
    chk("cmd_ready_in_send", 64'(cmd_ready), 64'd0);

    beats = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    budget = 0;
    while (!done && budget < 20000) begin
      if (prev_stall) begin
        chk("stall_data", m_axis_tdata, s_data);
        chk("stall_keep", 64'(m_axis_tkeep), 64'(s_keep));
        chk("stall_last", 64'(m_axis_tlast), 64'(s_last));
        chk("stall_user", 64'(m_axis_tuser), 64'(s_user));
        chk("stall_id", 64'(m_axis_tid), 64'(s_id));
        chk("stall_dest", 64'(m_axis_tdest), 64'(s_dest));
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
      end
      m_axis_tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        is_last = (beats == v.exp_beats - 1);
        model(int'(v.len), int'(v.seed), beats, e_data, e_keep);
        chk("beat_data", m_axis_tdata, e_data);
        chk("beat_keep", 64'(m_axis_tkeep), 64'(e_keep));
        chk("beat_last", 64'(m_axis_tlast), 64'(is_last));
        chk("beat_user", 64'(m_axis_tuser), is_last ? 64'(v.exp_last_user) : 64'd0);
        chk("beat_id", 64'(m_axis_tid), 64'(v.id));
        chk("beat_dest", 64'(m_axis_tdest), 64'(v.dest));
        if (beats == 0) chk("first_data_hand", m_axis_tdata, v.exp_first_data);
        if (is_last || m_axis_tlast) begin
          chk("beat_count", 64'(beats + 1), 64'(v.exp_beats));
          chk("last_keep_hand", 64'(m_axis_tkeep), 64'(v.exp_last_keep));
          chk("last_data_hand", m_axis_tdata, v.exp_last_data);
          done = 1'b1;
        end
        beats++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = m_axis_tvalid;
        s_data = m_axis_tdata;
        s_keep = m_axis_tkeep;
        s_last = m_axis_tlast;
        s_user = m_axis_tuser;
        s_id   = m_axis_tid;
        s_dest = m_axis_tdest;
      end
      @(negedge clk);
      budget++;
    end
    if (!done) chk("frame_timeout", 64'(beats), 64'(v.exp_beats));
    exp_frames++;
    chk("valid_after_last", 64'(m_axis_tvalid), 64'd0);
    chk("frame_count", 64'(frame_count), 64'(exp_frames));
    chk("busy_after_last", 64'(status_busy), 64'd0);
    chk("cmd_ready_after_last", 64'(cmd_ready), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
    chk({tag, "_side"}, {m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest}, 64'd0);
    chk({tag, "_status"}, {status_busy, status_zero_len, cmd_ready}, 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
  endtask

  initial begin
    int zl_cnt;
    int tv_cnt;
    vecs[0] = '{16'd20, 8'h10, 1'b0, 8'h11, 8'h22, 1'b0, 3, 8'h0F,
                64'h1716151413121110, 64'h0000000023222120, 1'b0};
    vecs[1] = '{16'd16, 8'hFE, 1'b0, 8'h01, 8'h02, 1'b0, 2, 8'hFF,
                64'h050403020100FFFE, 64'h0D0C0B0A09080706, 1'b0};
    vecs[2] = '{16'd9, 8'h00, 1'b1, 8'hA5, 8'h5A, 1'b0, 2, 8'h01,
                64'h0706050403020100, 64'h0000000000000008, 1'b1};
    vecs[3] = '{16'd1, 8'hAB, 1'b1, 8'h33, 8'h44, 1'b0, 1, 8'h01,
                64'h00000000000000AB, 64'h00000000000000AB, 1'b1};
    vecs[4] = '{16'd8, 8'h01, 1'b0, 8'h7E, 8'h81, 1'b0, 1, 8'hFF,
                64'h0807060504030201, 64'h0807060504030201, 1'b0};
    vecs[5] = '{16'd100, 8'h00, 1'b0, 8'hC3, 8'h3C, 1'b1, 13, 8'h0F,
                64'h0706050403020100, 64'h0000000063626160, 1'b0};
    vecs[6] = '{16'hFFFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0, 8192, 8'h7F,
                64'h0706050403020100, 64'h00FEFDFCFBFAF9F8, 1'b1};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_len = '0;
    cmd_seed = '0;
    cmd_bad = 1'b0;
    cmd_id = '0;
    cmd_dest = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Zero-length command: one status pulse, no beats, no count change.
    cmd_valid = 1'b1;
    cmd_len = 16'd0;
    cmd_seed = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    zl_cnt = 0;
    tv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (status_zero_len) zl_cnt++;
      if (m_axis_tvalid) tv_cnt++;
      chk("zero_len_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
    end
    chk("zero_len_pulses", 64'(zl_cnt), 64'd1);
    chk("zero_len_no_valid", 64'(tv_cnt), 64'd0);
    chk("zero_len_count", 64'(frame_count), 64'd0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset in the middle of a 5-beat frame.
    m_axis_tready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len = 16'd40;
    cmd_seed = 8'h33;
    cmd_id = 8'h9C;
    cmd_dest = 8'h6D;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    chk_all_zero("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_post_reset", 64'(cmd_ready), 64'd1);
    chk("count_post_reset", 64'(frame_count), 64'd0);
    chk("valid_post_reset", 64'(m_axis_tvalid), 64'd0);
    exp_frames = 0;
    run_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
